// File: rtl/reg_share_pkg.sv
// Shared types and constants for the reg_share_arb slice.
// Holds the arbiter state encoding and the write-counter width.
package reg_share_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   localparam int WR_CNT_W = 16;

endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// Combinational rotating-priority picker: the first unmasked request found
// when scanning from ptr upward, wrapping modulo NREQ.
module rr_pick
   import reg_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] mask,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [NREQ-1:0] cand_s;
   logic [IW-1:0]   pos_s;

   // scan candidates starting at ptr; the first hit wins
   always_comb begin
      cand_s = req & ~mask;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      pos_s  = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos_s = IW'((int'(ptr) + k) % NREQ);
         if (!any && cand_s[pos_s]) begin
            any           = 1'b1;
            idx           = pos_s;
            onehot[pos_s] = 1'b1;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin owner arbitration for one shared WIDTH-bit register.
// Optional write counter port wr_cnt is present when SHARE_WR_CNT_EN is defined.
module reg_share_arb
   import reg_share_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    din,
   output logic [NREQ-1:0]          gnt,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic [WIDTH-1:0]         q,
   output logic                     q_vld
`ifdef SHARE_WR_CNT_EN
   ,
   output logic [WR_CNT_W-1:0]      wr_cnt
`endif
);

   localparam int IW = $clog2(NREQ);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   state_e          state_r, state_s;
   logic [NREQ-1:0] gnt_r, gnt_s;
   logic [IW-1:0]   owner_r, owner_s;
   logic [IW-1:0]   ptr_r, ptr_s;
   logic [HW-1:0]   hold_r, hold_s;
   logic [WIDTH-1:0] q_r, q_s;
   logic            q_vld_r, q_vld_s;

   logic [NREQ-1:0] own_mask_s, pick_mask_s, win_oh_s;
   logic [IW-1:0]   nxt_ptr_s, pick_ptr_s, win_idx_s;
   logic            win_any_s, wr_s;

   assign own_mask_s  = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
   assign nxt_ptr_s   = (owner_r == IW'(NREQ - 1)) ? '0 : owner_r + IW'(1);
   // while owning, the search always starts just past the owner and skips it
   assign pick_ptr_s  = (state_r == OWN) ? nxt_ptr_s : ptr_r;
   assign pick_mask_s = (state_r == OWN) ? own_mask_s : '0;
   assign wr_s        = (state_r == OWN) && req[owner_r];

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req    (req),
      .mask   (pick_mask_s),
      .ptr    (pick_ptr_s),
      .onehot (win_oh_s),
      .idx    (win_idx_s),
      .any    (win_any_s)
   );

   // next-state, grant and shared-register update
   always_comb begin
      state_s = state_r;
      gnt_s   = gnt_r;
      owner_s = owner_r;
      ptr_s   = ptr_r;
      hold_s  = hold_r;
      q_s     = q_r;
      q_vld_s = 1'b0;

      if (wr_s) begin
         q_s     = din[int'(owner_r)*WIDTH +: WIDTH];
         q_vld_s = 1'b1;
      end else begin
         q_s = q_r;
      end

      case (state_r)
         IDLE: begin
            if (win_any_s) begin
               gnt_s   = win_oh_s;
               owner_s = win_idx_s;
               hold_s  = '0;
               state_s = OWN;
            end else begin
               gnt_s = '0;
            end
         end
         OWN: begin
            if (!wr_s) begin
               ptr_s  = nxt_ptr_s;
               hold_s = '0;
               if (win_any_s) begin
                  gnt_s   = win_oh_s;
                  owner_s = win_idx_s;
               end else begin
                  gnt_s   = '0;
                  state_s = IDLE;
               end
            end else if (hold_r == HOLD_LAST) begin
               // tenure expired: hand over, or start a fresh tenure for the same owner
               ptr_s  = nxt_ptr_s;
               hold_s = '0;
               if (win_any_s) begin
                  gnt_s   = win_oh_s;
                  owner_s = win_idx_s;
               end else begin
                  gnt_s = gnt_r;
               end
            end else begin
               hold_s = hold_r + HW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            gnt_s   = '0;
            hold_s  = '0;
         end
      endcase
   end

   // arbiter state and shared register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         gnt_r   <= '0;
         owner_r <= '0;
         ptr_r   <= '0;
         hold_r  <= '0;
         q_r     <= '0;
         q_vld_r <= 1'b0;
      end else begin
         state_r <= state_s;
         gnt_r   <= gnt_s;
         owner_r <= owner_s;
         ptr_r   <= ptr_s;
         hold_r  <= hold_s;
         q_r     <= q_s;
         q_vld_r <= q_vld_s;
      end
   end

   assign gnt   = gnt_r;
   assign owner = owner_r;
   assign q     = q_r;
   assign q_vld = q_vld_r;

`ifdef SHARE_WR_CNT_EN
   logic [WR_CNT_W-1:0] wr_cnt_r;

   // running count of completed writes, wraps naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt_r <= '0;
      end else if (wr_s) begin
         wr_cnt_r <= wr_cnt_r + WR_CNT_W'(1);
      end else begin
         wr_cnt_r <= wr_cnt_r;
      end
   end

   assign wr_cnt = wr_cnt_r;
`endif

endmodule

// File: tb/tb_reg_share_arb.sv
// Self-checking bench for reg_share_arb (NREQ=4, WIDTH=8, MAX_HOLD=4) against a
// tenure-level reference model; the wr_cnt test runs only with SHARE_WR_CNT_EN.
module tb_reg_share_arb;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MH = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] din = '0;
   logic [N-1:0]   gnt;
   logic [1:0]     owner;
   logic [W-1:0]   q;
   logic           q_vld;
`ifdef SHARE_WR_CNT_EN
   logic [15:0]    wr_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // reference model: who owns, how many writes in this tenure, where the search starts
   bit         m_busy;
   int         m_owner, m_ptr, m_ten, m_cnt;
   logic [W-1:0] m_q;
   bit         m_vld;

   reg_share_arb #(.NREQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .din   (din),
      .gnt   (gnt),
      .owner (owner),
      .q     (q),
      .q_vld (q_vld)
`ifdef SHARE_WR_CNT_EN
      ,
      .wr_cnt(wr_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_ten = 0; m_cnt = 0; m_q = '0; m_vld = 0;
   endtask

   function automatic int pick(logic [N-1:0] r, int start, int excl);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (r[j] && j != excl) return j;
      end
      return -1;
   endfunction

   task automatic model_step();
      int w;
      m_vld = 0;
      if (!m_busy) begin
         w = pick(req, m_ptr, -1);
         if (w >= 0) begin m_busy = 1; m_owner = w; m_ten = 0; end
      end else if (req[m_owner]) begin
         m_q = din[m_owner*W +: W];
         m_vld = 1;
         m_cnt++;
         m_ten++;
         if (m_ten == MH) begin
            m_ptr = (m_owner + 1) % N;
            w = pick(req, m_ptr, m_owner);
            if (w >= 0) m_owner = w;
            m_ten = 0;
         end
      end else begin
         m_ptr = (m_owner + 1) % N;
         w = pick(req, m_ptr, m_owner);
         if (w >= 0) begin m_owner = w; m_ten = 0; end
         else m_busy = 0;
      end
   endtask

   function automatic logic [N-1:0] exp_gnt();
      logic [N-1:0] g;
      g = '0;
      if (m_busy) g[m_owner] = 1'b1;
      return g;
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req = '0;
      rst = 1'b0;
      model_reset();
      #2;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (gnt !== 4'b0000 || q !== 8'h00 || q_vld !== 1'b0) begin
         bad++; $display("FAIL reset_init gnt=%b q=%h q_vld=%b expected 0000/00/0", gnt, q, q_vld);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      din[1*W +: W] = 8'h3C;
      req = 4'b0010;
      cycle(); cycle(); cycle();
      total++;
      if (gnt !== 4'b0010 || q !== 8'h3C || q_vld !== 1'b1) begin
         bad++; $display("FAIL pre_abort gnt=%b q=%h q_vld=%b expected 0010/3c/1", gnt, q, q_vld);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (gnt !== 4'b0000 || q !== 8'h00 || q_vld !== 1'b0) begin
         bad++; $display("FAIL async_abort gnt=%b q=%h q_vld=%b expected 0000/00/0", gnt, q, q_vld);
      end
      model_reset();
      #2;
      rst = 1'b1;
      req = 4'b1111;
      cycle();
      total++;
      if (gnt !== 4'b0001 || owner !== 2'd0 || gnt !== exp_gnt()) begin
         bad++; $display("FAIL first_grant gnt=%b owner=%0d expected 0001/0", gnt, owner);
      end
   endtask

   task automatic test_single();
      apply_reset();
      din[2*W +: W] = 8'hA5;
      req = 4'b0100;
      cycle();
      total++;
      if (gnt !== 4'b0100 || q_vld !== 1'b0 || owner !== 2'd2) begin
         bad++; $display("FAIL single_gnt gnt=%b q_vld=%b owner=%0d expected 0100/0/2", gnt, q_vld, owner);
      end
      cycle();
      total++;
      if (q !== 8'hA5 || q_vld !== 1'b1 || q !== m_q) begin
         bad++; $display("FAIL single_wr q=%h q_vld=%b expected a5/1", q, q_vld);
      end
   endtask

   task automatic test_round_robin();
      logic [W-1:0] exp_q;
      apply_reset();
      din = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      cycle();
      for (int k = 0; k < 20; k++) begin
         cycle();
         exp_q = din[((k / MH) % N)*W +: W];
         total++;
         if (q !== exp_q || q_vld !== 1'b1 || gnt !== exp_gnt() || owner !== 2'(m_owner) || q !== m_q) begin
            bad++; $display("FAIL rr_seq k=%0d q=%h q_vld=%b gnt=%b owner=%0d expected q=%h q_vld=1 gnt=%b owner=%0d",
                            k, q, q_vld, gnt, owner, exp_q, exp_gnt(), m_owner);
         end
      end
   endtask

   task automatic test_release();
      apply_reset();
      din[1*W +: W] = 8'h5A;
      din[3*W +: W] = 8'hC3;
      req = 4'b0010;
      cycle(); cycle();
      req = 4'b1000;
      cycle();
      total++;
      if (gnt !== 4'b1000 || q !== 8'h5A || q_vld !== 1'b0 || gnt !== exp_gnt()) begin
         bad++; $display("FAIL release_handover gnt=%b q=%h q_vld=%b expected 1000/5a/0", gnt, q, q_vld);
      end
      cycle();
      total++;
      if (q !== 8'hC3 || q_vld !== 1'b1 || owner !== 2'd3) begin
         bad++; $display("FAIL release_next_wr q=%h q_vld=%b owner=%0d expected c3/1/3", q, q_vld, owner);
      end
   endtask

   task automatic test_hold();
      apply_reset();
      din[3*W +: W] = 8'h77;
      req = 4'b1000;
      for (int i = 0; i < 12; i++) begin
         cycle();
         total++;
         if (gnt !== 4'b1000 || q_vld !== (i != 0) || q_vld !== m_vld || q !== m_q) begin
            bad++; $display("FAIL hold_cycle i=%0d gnt=%b q_vld=%b q=%h expected 1000/%0d/%h", i, gnt, q_vld, q, (i != 0), m_q);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         req = N'($urandom_range(0, 15));
         din = {$urandom, $urandom} % (64'd1 << (N*W));
         cycle();
         total++;
         if (gnt !== exp_gnt() || q !== m_q || q_vld !== m_vld || (m_busy && owner !== 2'(m_owner))) begin
            bad++; $display("FAIL random i=%0d gnt=%b owner=%0d q=%h q_vld=%b expected gnt=%b owner=%0d q=%h q_vld=%0d",
                            i, gnt, owner, q, q_vld, exp_gnt(), m_owner, m_q, m_vld);
         end
`ifdef SHARE_WR_CNT_EN
         total++;
         if (wr_cnt !== 16'(m_cnt)) begin
            bad++; $display("FAIL random_wr_cnt i=%0d wr_cnt=%0d expected %0d", i, wr_cnt, m_cnt);
         end
`endif
      end
   endtask

`ifdef SHARE_WR_CNT_EN
   task automatic test_wr_cnt();
      apply_reset();
      din = 32'h0403_0201;
      req = 4'b1111;
      for (int i = 0; i < 70010 && m_cnt < 70000; i++) cycle();
      total++;
      if (wr_cnt !== 16'd4464 || m_cnt != 70000) begin
         bad++; $display("FAIL wr_cnt_wrap wr_cnt=%0d model_writes=%0d expected 4464 after 70000", wr_cnt, m_cnt);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_release();
      test_hold();
      test_random();
`ifdef SHARE_WR_CNT_EN
      test_wr_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
